alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Issue/writeback stage sitting directly upstream of the 8-bit ALU. It holds a 4×8-bit register file, accepts one instruction at a time over a valid/ready handshake, and drives the ALU's operand and operation inputs from registered values. It captures the ALU result and carry, writes the result back to the destination register, and presents it downstream with flags.

## Interface
Parameters:
- `NREGS`, 4: register-file depth; register fields are log2(NREGS) bits wide.
- `RESET_VAL`, 8'h00: reset value of every register-file entry.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: stage can accept an instruction.
- `in_op` in 3: operation; 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 load-immediate.
- `in_rd` / `in_rs1` / `in_rs2` in 2 each: destination and source register indices.
- `in_imm` in 8: immediate, used only by load-immediate.
- `alu_operand1` / `alu_operand2` out 8 each: registered ALU operands.
- `alu_operation` out 3: registered ALU operation.
- `alu_result` in 8: ALU result, combinational from the ALU outputs.
- `alu_carry` in 1: ALU carry of operand1+operand2.
- `out_valid` out 1: writeback result available.
- `out_ready` in 1: downstream accepts the result.
- `out_result` out 8: value written to `rd`.
- `out_rd` out 2: destination index.
- `out_carry` / `out_zero` / `out_div0` out 1 each: flags.

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch op/rd/imm; set `alu_operand1`=R[rs1], `alu_operand2`=R[rs2], `alu_operation`=op; go to EXEC.
- EXEC:
  - `in_ready`=0. ALU is combinational; capture the result this cycle.
  - Result selection:
    - Op 111: result=imm; ALU ignored.
    - Op 011 with operand2==0: result=8'hFF, div0=1; ALU ignored.
    - Otherwise: result=`alu_result`.
  - carry=`alu_carry` for op 000, else 0.
  - zero=(result==0).
  - Write R[rd]=result; go to WB.
- WB:
  - `out_valid`=1; result, rd and flags held stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- Register reads in IDLE see writes committed in any earlier EXEC cycle; no bypass is needed because the stage is not overlapped.
- `rs1`==`rs2` and `rd`==`rs1` are legal. Sources are read before the write.
- Arithmetic is truncated to 8 bits, as computed by the ALU. Sub and mul wrap modulo 256.

## Timing
- Handshake at cycle N → ALU inputs valid from N+1 → register write at the N+1 edge → `out_valid` from N+2.
- Best case is one instruction per 3 cycles. WB stalls indefinitely while `out_ready`=0.
- `out_valid` must not drop without `out_ready`. Outputs must not change while stalled.
- `in_valid` while not ready is ignored; the upstream must hold the instruction.
- Reset values (on a `rst_n` low edge):
  - State IDLE; registers `RESET_VAL`.
  - All `alu_*` outputs 0; `out_*` 0; `in_ready`=1 from the first cycle after release.
- Reset mid-operation abandons the instruction with no writeback. A reset in EXEC overrides the register write.

## Structure
- Shared package: 3-bit opcode constants (ADD..XOR, LDI=111), state encoding, the div-by-zero fill constant 8'hFF.
- Natural sub-module: `regfile_nx8`, a parameterised 2-read/1-write register file with synchronous reset.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- After reset, load-immediate R1=8'h0F and R2=8'hF2, then ADD R3=R1+R2.
  - Required: `out_result`=8'h01, `out_carry`=1, `out_zero`=0.
  - Required: `out_valid` exactly 2 cycles after the ADD handshake.
- SUB R0=R2-R1 with R2=5, R1=7.
  - Required: result 8'hFE, carry 0.
  - Required: `alu_operation`=001 during EXEC.
- DIV R3=R1/R0 with R0=0.
  - Required: result 8'hFF, `out_div0`=1, R3 reads 8'hFF afterwards.
- XOR R1=R1^R1 with `out_ready` held low for 5 cycles.
  - Required: zero=1, outputs stable, `in_ready`=0 throughout; returns to IDLE on the cycle after `out_ready`=1.
- Assert reset during EXEC of a load-immediate R2=8'hAA.
  - Required: R2 stays 8'h00; all outputs return to reset values.
- `in_valid` pulsed while busy.
  - Required: no second instruction is accepted or executed.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_pkg
// Shared constants for the ALU issue/writeback stage:
//   - 3-bit opcodes (ADD..XOR, LDI)
//   - FSM state encoding (IDLE, EXEC, WB)
//   - result written when a divide has a zero divisor
//   - helper that picks the written-back value in EXEC
// -----------------------------------------------------------------------------
package alu_exec_stage_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [7:0] DIV0_FILL = 8'hFF;

  // Load-immediate and divide-by-zero bypass the ALU; everything else
  // takes the ALU's truncated 8-bit result as-is.
  function automatic logic [7:0] select_result(input logic [2:0] op,
                                               input logic       div0,
                                               input logic [7:0] imm,
                                               input logic [7:0] alu_res);
    if (op == OP_LDI)   return imm;
    else if (div0)      return DIV0_FILL;
    else                return alu_res;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_if
// Bundles the three buses of the stage:
//   in_*  : instruction handshake from upstream (valid/ready)
//   alu_* : registered operands/operation to the ALU, result/carry back
//   out_* : writeback result handshake to downstream (valid/ready)
// Modports:
//   slave  : the exec stage itself
//   master : the surrounding environment (upstream, ALU, downstream)
// -----------------------------------------------------------------------------
interface alu_exec_stage_if #(
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [7:0]    in_imm;

  logic [7:0]    alu_operand1;
  logic [7:0]    alu_operand2;
  logic [2:0]    alu_operation;
  logic [7:0]    alu_result;
  logic          alu_carry;

  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_result;
  logic [AW-1:0] out_rd;
  logic          out_carry;
  logic          out_zero;
  logic          out_div0;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  alu_result, alu_carry, out_ready,
    output in_ready, alu_operand1, alu_operand2, alu_operation,
    output out_valid, out_result, out_rd, out_carry, out_zero, out_div0
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output alu_result, alu_carry, out_ready,
    input  in_ready, alu_operand1, alu_operand2, alu_operation,
    input  out_valid, out_result, out_rd, out_carry, out_zero, out_div0
  );

endinterface

// File: rtl/alu_exec_stage_regfile.sv
// -----------------------------------------------------------------------------
// regfile_nx8
// NREGS x 8-bit register file, two combinational read ports, one write port.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   i_rd_addr1/2          : read addresses
//   o_rd_data1/2          : read data (pre-write value in the write cycle)
//   i_we, i_wr_addr/data  : write enable, address, data
// -----------------------------------------------------------------------------
module regfile_nx8 #(
  parameter int         NREGS     = 4,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int        AW        = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_rd_addr1,
  input  logic [AW-1:0] i_rd_addr2,
  output logic [7:0]    o_rd_data1,
  output logic [7:0]    o_rd_data2,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data
);

  logic [7:0] r_mem [NREGS];

  assign o_rd_data1 = r_mem[i_rd_addr1];
  assign o_rd_data2 = r_mem[i_rd_addr2];

  // NOTE: this array is reset entry by entry, so it maps to flops rather than
  // a RAM macro; reset takes priority so a reset during a write discards it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= RESET_VAL;
    end else if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Issue/writeback stage in front of an external combinational 8-bit ALU.
// Accepts one instruction per handshake, reads two sources from a small
// register file, drives registered operands to the ALU, captures the result
// one cycle later, writes it back and offers it downstream until accepted.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alu_exec_stage_if.slave (in_*, alu_*, out_* buses)
// -----------------------------------------------------------------------------
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int         NREGS     = 4,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int        AW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_stage_if.slave bus
);

  logic [1:0]    r_state;
  logic [AW-1:0] r_rd;
  logic [7:0]    r_imm;
  logic [7:0]    r_operand1;
  logic [7:0]    r_operand2;
  logic [2:0]    r_operation;
  logic [7:0]    r_out_result;
  logic [AW-1:0] r_out_rd;
  logic          r_out_carry;
  logic          r_out_zero;
  logic          r_out_div0;

  logic [7:0]    w_rd_data1;
  logic [7:0]    w_rd_data2;
  logic          w_div0;
  logic          w_carry;
  logic [7:0]    w_result;
  logic          w_we;

  // Write-back happens only in EXEC; the regfile's own reset overrides it.
  assign w_we = (r_state == ST_EXEC);

  regfile_nx8 #(
    .NREGS     (NREGS),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_addr1 (bus.in_rs1),
    .i_rd_addr2 (bus.in_rs2),
    .o_rd_data1 (w_rd_data1),
    .o_rd_data2 (w_rd_data2),
    .i_we       (w_we),
    .i_wr_addr  (r_rd),
    .i_wr_data  (w_result)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_div0   = 1'b0;
    w_carry  = 1'b0;
    if (r_operation == OP_DIV && r_operand2 == 8'h00) w_div0 = 1'b1;
    if (r_operation == OP_ADD) w_carry = bus.alu_carry;
    w_result = select_result(r_operation, w_div0, r_imm, bus.alu_result);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rd         <= '0;
      r_imm        <= 8'h00;
      r_operand1   <= 8'h00;
      r_operand2   <= 8'h00;
      r_operation  <= 3'b000;
      r_out_result <= 8'h00;
      r_out_rd     <= '0;
      r_out_carry  <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_div0   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_rd        <= bus.in_rd;
            r_imm       <= bus.in_imm;
            r_operand1  <= w_rd_data1;
            r_operand2  <= w_rd_data2;
            r_operation <= bus.in_op;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_out_result <= w_result;
          r_out_rd     <= r_rd;
          r_out_carry  <= w_carry;
          r_out_zero   <= (w_result == 8'h00);
          r_out_div0   <= w_div0;
          r_state      <= ST_WB;
        end
        ST_WB: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (r_state == ST_IDLE);
  assign bus.out_valid     = (r_state == ST_WB);
  assign bus.alu_operand1  = r_operand1;
  assign bus.alu_operand2  = r_operand2;
  assign bus.alu_operation = r_operation;
  assign bus.out_result    = r_out_result;
  assign bus.out_rd        = r_out_rd;
  assign bus.out_carry     = r_out_carry;
  assign bus.out_zero      = r_out_zero;
  assign bus.out_div0      = r_out_div0;

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
// Drives alu_exec_stage with a table of directed instructions (expected
// writeback values hand-computed), then hand-written sequences for a stalled
// writeback, in_valid while busy and reset during EXEC. A behavioural 8-bit
// ALU stands in for the real one downstream of the stage.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_exec_stage_if #(.NREGS(4)) bus ();

  alu_exec_stage #(.NREGS(4), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ALU: combinational, 8-bit truncated, carry of op1+op2.
  logic [8:0]  w_sum;
  logic [15:0] w_prod;
  always_comb begin
    w_sum          = {1'b0, bus.alu_operand1} + {1'b0, bus.alu_operand2};
    w_prod         = bus.alu_operand1 * bus.alu_operand2;
    bus.alu_carry  = w_sum[8];
    bus.alu_result = 8'h00;
    case (bus.alu_operation)
      OP_ADD: bus.alu_result = w_sum[7:0];
      OP_SUB: bus.alu_result = bus.alu_operand1 - bus.alu_operand2;
      OP_MUL: bus.alu_result = w_prod[7:0];
      OP_DIV: bus.alu_result = (bus.alu_operand2 == 8'h00) ? 8'h00
                               : bus.alu_operand1 / bus.alu_operand2;
      OP_AND: bus.alu_result = bus.alu_operand1 & bus.alu_operand2;
      OP_OR:  bus.alu_result = bus.alu_operand1 | bus.alu_operand2;
      OP_XOR: bus.alu_result = bus.alu_operand1 ^ bus.alu_operand2;
      default: bus.alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [7:0] imm;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       d0;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then performs one handshake. Returns with
  // the stage in EXEC, 1 time unit after the handshake edge.
  task automatic issue(input string tag, input logic [2:0] op,
                       input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Full instruction: handshake, EXEC checks, WB checks, retire.
  task automatic run_vec(input string tag, input vec_t v);
    issue(tag, v.op, v.rd, v.rs1, v.rs2, v.imm);
    check($sformatf("%s exec op", tag), 32'(bus.alu_operation), 32'(v.op));
    check($sformatf("%s exec valid", tag), 32'(bus.out_valid), 32'd0);
    tick();
    check($sformatf("%s out_valid", tag), 32'(bus.out_valid), 32'd1);
    check($sformatf("%s result", tag), 32'(bus.out_result), 32'(v.res));
    check($sformatf("%s rd", tag), 32'(bus.out_rd), 32'(v.rd));
    check($sformatf("%s flags", tag),
          32'({bus.out_carry, bus.out_zero, bus.out_div0}),
          32'({v.c, v.z, v.d0}));
    retire();
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'd1);
    check($sformatf("%s out_valid", tag), 32'(bus.out_valid), 32'd0);
    check($sformatf("%s alu_ops", tag),
          32'({bus.alu_operand1, bus.alu_operand2, bus.alu_operation}), 32'd0);
    check($sformatf("%s outs", tag),
          32'({bus.out_result, bus.out_rd, bus.out_carry, bus.out_zero,
               bus.out_div0}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    n_tests = 0;
    n_fail  = 0;

    //              op      rd     rs1    rs2    imm    res    c     z     d0
    vecs[0]  = '{OP_LDI, 2'd1, 2'd0, 2'd0, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_LDI, 2'd2, 2'd0, 2'd0, 8'hF2, 8'hF2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{OP_LDI, 2'd2, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_LDI, 2'd1, 2'd0, 2'd0, 8'h07, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_SUB, 2'd0, 2'd2, 2'd1, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_MUL, 2'd3, 2'd2, 2'd1, 8'h00, 8'h23, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_AND, 2'd3, 2'd1, 2'd2, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_OR,  2'd3, 2'd1, 2'd2, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_LDI, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{OP_DIV, 2'd3, 2'd1, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{OP_OR,  2'd2, 2'd3, 2'd3, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{OP_LDI, 2'd1, 2'd0, 2'd0, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_MUL, 2'd2, 2'd1, 2'd1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{OP_LDI, 2'd0, 2'd0, 2'd0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{OP_DIV, 2'd3, 2'd1, 2'd0, 8'h00, 8'h15, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{OP_SUB, 2'd0, 2'd0, 2'd1, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{OP_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 8'h86, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{OP_XOR, 2'd2, 2'd1, 2'd0, 8'h00, 8'hC6, 1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.in_rd     = 2'd0;
    bus.in_rs1    = 2'd0;
    bus.in_rs2    = 2'd0;
    bus.in_imm    = 8'h00;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Table: R0..R3 end as 86, 40, C6, 15.
    for (int i = 0; i < NVEC; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Stalled writeback: XOR R1=R1^R1, out_ready low for 5 cycles.
    issue("stall", OP_XOR, 2'd1, 2'd1, 2'd1, 8'h00);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("stall%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      check($sformatf("stall%0d out", k),
            32'({bus.out_result, bus.out_rd, bus.out_zero, bus.out_carry}),
            32'({8'h00, 2'd1, 1'b1, 1'b0}));
      tick();
    end
    retire();
    check("stall idle in_ready", 32'(bus.in_ready), 32'd1);
    check("stall idle valid", 32'(bus.out_valid), 32'd0);

    // in_valid held high while busy must not start a second instruction.
    issue("busy", OP_ADD, 2'd3, 2'd0, 2'd0, 8'h00);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_LDI;
    bus.in_rd    = 2'd3;
    bus.in_imm   = 8'h77;
    tick();
    check("busy result", 32'({bus.out_valid, bus.out_result, bus.out_carry}),
          32'({1'b1, 8'h0C, 1'b1}));
    tick();
    check("busy held", 32'({bus.out_valid, bus.out_result}), 32'({1'b1, 8'h0C}));
    bus.in_valid = 1'b0;
    retire();
    tick();
    check("busy no second", 32'({bus.in_ready, bus.out_valid}), 32'({1'b1, 1'b0}));
    v = '{OP_OR, 2'd2, 2'd3, 2'd3, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b0};
    run_vec("busy R3", v);

    // Reset during EXEC of LDI R2=AA: write dropped, outputs back to reset.
    issue("rst", OP_LDI, 2'd2, 2'd0, 2'd0, 8'hAA);
    check("rst in exec", 32'(bus.alu_operation), 32'(OP_LDI));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("rst");
    v = '{OP_OR, 2'd3, 2'd2, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    run_vec("rst R2", v);
    v = '{OP_ADD, 2'd1, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    run_vec("rst R0", v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
